dmem_wbuf_ctrl: RTL
===================

DMEM_WBUF_CTRL -- requirements
Module: dmem_wbuf_ctrl

Interface
REQ-001 Parameter AW, default 10, word-address width of the data RAM (2^AW 32-bit words).
REQ-002 Parameter DEPTH, default 4, write-buffer entries; legal values are 2, 4 and 8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rden  input  1  CPU Mem-stage load request.
REQ-006 rdaddr  input  32  CPU load byte address.
REQ-007 wme  input  1  CPU Mem-stage store request.
REQ-008 maddr  input  32  CPU store byte address.
REQ-009 wdata  input  32  CPU store data.
REQ-010 memdata  output  32  load data to the CPU Wr stage.
REQ-011 stall  output  1  combinational; CPU holds the Mem stage while high.
REQ-012 ram_addr  output  AW  RAM word address.
REQ-013 ram_we  output  1  RAM write strobe.
REQ-014 ram_wdata  output  32  RAM write data.
REQ-015 ram_rdata  input  32  RAM synchronous read data, valid one cycle after the address.
REQ-016 wb_count  output  4  number of valid write-buffer entries.

Function
REQ-017 Word index of any address SHALL be addr[AW+1:2]; bits [1:0] and bits above AW+1 are ignored.
REQ-018 Write buffer: in-order FIFO of {index, data} with DEPTH entries, head/tail pointers wrapping modulo DEPTH.
REQ-019 Store accept: wme=1 and stall=0 SHALL enqueue at tail in that cycle; wb_count increments unless a drain occurs in the same cycle, in which case it is unchanged.
REQ-020 stall SHALL equal wme AND (wb_count==DEPTH) AND rden; while stall=1, nothing is enqueued and no read is issued.
REQ-021 Drain: when rden=0 and wb_count>0, the head entry SHALL be written (ram_we=1, ram_addr=head index, ram_wdata=head data) and dequeued in that cycle.
REQ-022 Forced drain: when wb_count==DEPTH, wme=1 and rden=0, the head entry drains and the new store enqueues in the same cycle.
REQ-023 Read issue: when rden=1 and stall=0, ram_addr SHALL equal the rdaddr index, ram_we=0, and no drain occurs.
REQ-024 Forwarding: the read index SHALL be compared with every valid buffer entry and with the same-cycle accepted store; the youngest match wins, and the same-cycle store counts as youngest.
REQ-025 Hit/data SHALL be registered as fwd_hit_q/fwd_data_q; memdata = fwd_hit_q ? fwd_data_q : ram_rdata, giving one-cycle load latency for both paths.
REQ-026 On a cycle with no read issued, fwd_hit_q and fwd_data_q SHALL hold their values.
REQ-027 When idle (rden=0, wme=0, wb_count=0), ram_we=0 and ram_addr SHALL hold its last value.
REQ-028 A store whose index matches an older buffer entry SHALL be enqueued as a new entry, with no merging, so RAM sees the writes in program order.
REQ-029 wb_count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-030 On rst_n=0, asynchronously: head=tail=0, wb_count=0, ram_we=0, ram_addr=0, fwd_hit_q=1, fwd_data_q=0; hence memdata=0.
REQ-031 Reset mid-drain or mid-read SHALL discard all buffered stores; no RAM write is issued in the cycle rst_n is low.
REQ-032 stall SHALL be 0 while rst_n=0.

Verification
REQ-033 Store 0x11223344 to 0x40, then load 0x40 on the next cycle with rden=1 -> memdata=0x11223344 one cycle later, via the forward path, ram_we=0.
REQ-034 Stores to 0x40 (A), 0x44 (B), 0x40 (C) with rden held high; then load 0x40 -> memdata=C; with rden then low for 3 cycles -> RAM writes occur in order 0x10:A, 0x11:B, 0x10:C, and wb_count goes 3,2,1,0.
REQ-035 DEPTH=4: fill 4 stores with rden=1, then a 5th store with rden=1 -> stall=1 and wb_count stays 4; drop rden -> head drains, 5th store enqueues in the same cycle, wb_count=4, stall=0.
REQ-036 Load of 0x80 (not buffered) with RAM word 0x20=0xDEADBEEF -> ram_addr=0x20 in the issue cycle and memdata=0xDEADBEEF next cycle.
REQ-037 Assert rst_n=0 with wb_count=3 -> wb_count=0, memdata=0, and ram_we=0 immediately, with none of the 3 stores ever written.
REQ-038 Load to 0x1040 with AW=10 -> aliases to word 0x010, and the byte offset 0x43 vs 0x40 hits the same entry.

Source files
------------

// File: rtl/dmem_wbuf_ctrl.sv
// Data-memory controller with an in-order store write buffer.
// Loads forward from buffered stores; stores drain to RAM on cycles without a load.
module dmem_wbuf_ctrl #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rden,
    input  logic [31:0]   rdaddr,
    input  logic          wme,
    input  logic [31:0]   maddr,
    input  logic [31:0]   wdata,
    output logic [31:0]   memdata,
    output logic          stall,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic [3:0]    wb_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [31:0]   data;
    } wb_entry_t;

    wb_entry_t     buf_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] ram_addr_q;
    logic          fwd_hit_q, fwd_hit_d;
    logic [31:0]   fwd_data_q, fwd_data_d;

    logic          full_c;
    logic          rd_issue_c;
    logic          st_acc_c;
    logic          drain_c;
    logic [AW-1:0] rd_idx_c;
    logic [AW-1:0] st_idx_c;
    logic [PW-1:0] slot_c;
    logic          unused_addr_bits;

    assign rd_idx_c = rdaddr[AW+1:2];
    assign st_idx_c = maddr[AW+1:2];
    assign unused_addr_bits = ^{rdaddr[31:AW+2], rdaddr[1:0], maddr[31:AW+2], maddr[1:0]};

    // Read and store acceptance; a load always takes priority over draining.
    always_comb begin
        full_c     = (count_q == CW'(DEPTH));
        stall      = wme & full_c & rden;
        rd_issue_c = rst_n & rden & ~stall;
        st_acc_c   = rst_n & wme & ~stall;
        drain_c    = rst_n & ~rden & (count_q != '0);
    end

    always_comb begin
        head_d  = drain_c ? head_q + PW'(1) : head_q;
        tail_d  = st_acc_c ? tail_q + PW'(1) : tail_q;
        count_d = count_q + {3'b000, st_acc_c} - {3'b000, drain_c};
    end

    // Scan oldest to youngest so the last match wins; the same-cycle store is youngest of all.
    always_comb begin
        fwd_hit_d  = fwd_hit_q;
        fwd_data_d = fwd_data_q;
        slot_c     = head_q;
        if (rd_issue_c) begin
            fwd_hit_d = 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_c = head_q + PW'(i);
                if ((CW'(i) < count_q) && (buf_q[slot_c].idx == rd_idx_c)) begin
                    fwd_hit_d  = 1'b1;
                    fwd_data_d = buf_q[slot_c].data;
                end
            end
            if (st_acc_c && (st_idx_c == rd_idx_c)) begin
                fwd_hit_d  = 1'b1;
                fwd_data_d = wdata;
            end
        end
    end

    always_comb begin
        ram_we    = drain_c;
        ram_wdata = buf_q[head_q].data;
        if (rd_issue_c) begin
            ram_addr = rd_idx_c;
        end else if (drain_c) begin
            ram_addr = buf_q[head_q].idx;
        end else begin
            ram_addr = ram_addr_q;
        end
    end

    assign memdata  = fwd_hit_q ? fwd_data_q : ram_rdata;
    assign wb_count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ram_addr_q <= '0;
            fwd_hit_q  <= 1'b1;
            fwd_data_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ram_addr_q <= ram_addr;
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Payload storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (st_acc_c) begin
            buf_q[tail_q] <= '{idx: st_idx_c, data: wdata};
        end
    end

endmodule
